sha256_stream_core: RTL

- Multi-block SHA-256/SHA-224 hash engine with its own block buffer and chaining state.
- Accepts a pre-padded message as a stream of DATA_W-bit writes and assembles each 512-bit block internally; the engine needs no external 512-bit staging register.
- Runs one compression round per cycle and chains intermediate hash state across blocks.
- Presents the digest with a level valid; sits between the bus-write logic and the result registers.

---
 rtl/sha256_stream_core_if.sv | 18 +
 rtl/sha256_stream_core.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sha256_stream_core_if.sv
// Beat-write / digest handshake between the bus-write logic and the SHA-256 core.
interface sha256_stream_core_if #(
  parameter int DATA_W = 128
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              last;
  logic              ready;
  logic              busy;
  logic [255:0]      hashvalue;
  logic              valid;
  logic              err;

  modport master (output wr_en, wr_data, last,
                  input  ready, busy, hashvalue, valid, err);
  modport slave  (input  wr_en, wr_data, last,
                  output ready, busy, hashvalue, valid, err);
endinterface

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256/SHA-224 engine: collects a pre-padded 512-bit block from
// DATA_W-bit beats, runs one round per cycle and chains H across blocks.
module sha256_stream_core #(
  parameter int DATA_W = 128,
  parameter int SHA224 = 0
) (
  input  logic clk,
  input  logic clr,
  sha256_stream_core_if.slave bus
);
  localparam int BEATS = 512 / DATA_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [0:7][31:0] IV = (SHA224 != 0) ?
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4 :
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {COLLECT, LOAD, ROUND, UPDATE} state_t;

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] ep1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] sg0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] sg1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [5:0]        rnd;
  logic              first_blk, last_q;
  logic [511:0]      blk_q;
  logic [0:7][31:0]  hq, wk, base, nh;
  logic [0:15][31:0] wq;
  logic [31:0]       t1, t2, wnext;
  logic [255:0]      nh_flat;
  logic              ready_q, busy_q, valid_q, err_q;
  logic [255:0]      hash_q;

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.hashvalue = hash_q;
  assign nh_flat       = nh;

  // Round datapath, next schedule word and chained-state sum for UPDATE.
  always_comb begin
    t1    = wk[7] + ep1(wk[4]) + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[rnd] + wq[0];
    t2    = ep0(wk[0]) + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
    wnext = sg1(wq[14]) + wq[9] + sg0(wq[1]) + wq[0];
    base  = first_blk ? IV : hq;
    for (int i = 0; i < 8; i++) nh[i] = base[i] + wk[i];
  end

  // Control FSM plus all datapath registers; outputs are registered.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= COLLECT;
      cnt       <= '0;
      rnd       <= '0;
      first_blk <= 1'b1;
      last_q    <= 1'b0;
      blk_q     <= '0;
      hq        <= '0;
      wk        <= '0;
      wq        <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      hash_q    <= '0;
    end else begin
      // A write outside COLLECT is dropped and flagged until the next clear.
      if (bus.wr_en && state != COLLECT) err_q <= 1'b1;
      case (state)
        COLLECT: if (bus.wr_en) begin
          blk_q[511 - int'(cnt) * DATA_W -: DATA_W] <= bus.wr_data;
          valid_q <= 1'b0;
          if (cnt == CW'(BEATS - 1)) begin
            cnt     <= '0;
            last_q  <= bus.last;
            state   <= LOAD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD: begin
          wk    <= base;
          wq    <= blk_q;
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          wk  <= {t1 + t2, wk[0], wk[1], wk[2], wk[3] + t1, wk[4], wk[5], wk[6]};
          wq  <= {wq[1:15], wnext};
          rnd <= rnd + 6'd1;
          if (rnd == 6'd63) state <= UPDATE;
        end
        default: begin
          hq <= nh;
          if (last_q) begin
            hash_q    <= (SHA224 != 0) ? {nh_flat[255:32], 32'h0} : nh_flat;
            valid_q   <= 1'b1;
            first_blk <= 1'b1;
          end else begin
            first_blk <= 1'b0;
          end
          state   <= COLLECT;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
